pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the load-enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It covers load-use hazards, EX-resolved control redirects (taken branch, JAL, JALR) and multi-cycle data-memory accesses, using a ready handshake with a timeout. It also keeps saturating performance counters for stall and flush cycles.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before the access is abandoned (minimum 2)
CNT_W, 32, width of the stall_cnt and flush_cnt performance counters

Ports:
clk  input  1  rising-edge clock
nrst  input  1  asynchronous active-low reset
id_rs1  input  5  rs1 field of the instruction in ID
id_rs2  input  5  rs2 field of the instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_rd  input  5  rd of the instruction in EX
ex_MemRead  input  1  EX instruction is a load
ex_redirect  input  1  EX resolved a taken branch, JAL or JALR; PC mux selects the target
mem_req  input  1  MEM instruction accesses data memory (MemRead or MemWrite)
mem_ready  input  1  data memory completes the access this cycle
pc_en  output  1  PC load enable
ifid_en  output  1  IF/ID load enable
ifid_flush  output  1  IF/ID loads a NOP (all-zero instruction and controls)
idex_en  output  1  ID/EX load enable
idex_flush  output  1  ID/EX loads zero controls (bubble)
exmem_en  output  1  EX/MEM load enable
memwb_bubble  output  1  MEM/WB loads zero controls (RegWrite=0, MemtoReg=0)
mem_busy  output  1  FSM is in MEM_WAIT
mem_err  output  1  sticky; set on timeout
stall_cnt  output  CNT_W  cycles with pc_en=0
flush_cnt  output  CNT_W  cycles with ifid_flush=1

Behaviour:
- Reset (nrst=0, async): state=RUN, wait counter=0, mem_err=0, stall_cnt=0, flush_cnt=0. Combinational outputs then evaluate as RUN with no hazard: all enables=1, flushes/bubble=0, mem_busy=0.
- States: RUN, MEM_WAIT. Outputs are Mealy: a function of state and current inputs. State and counters are registered.
- mem_hold = mem_req & ~mem_ready & (state==RUN or wait counter < MEM_TIMEOUT-1).
- Priority, highest first: mem_hold, then ex_redirect, then load-use.
- mem_hold=1:
  - pc_en=ifid_en=idex_en=exmem_en=0; memwb_bubble=1.
  - ifid_flush=idex_flush=0. A pending redirect or load-use is deferred, not lost.
- RUN with mem_req&~mem_ready: next state MEM_WAIT, wait counter<=1.
- MEM_WAIT, per cycle:
  - mem_ready=1: leave hold this same cycle (enables=1, memwb_bubble=0), next state RUN, counter<=0. Lower-priority rules apply in this cycle.
  - mem_ready=0 and counter < MEM_TIMEOUT-1: counter++.
  - mem_ready=0 and counter = MEM_TIMEOUT-1: timeout. mem_hold=0, memwb_bubble=1 (the access is discarded, no writeback), mem_err<=1, next state RUN, counter<=0. The pipeline advances.
- ex_redirect (no mem_hold): pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_flush=1, exmem_en=1. Two wrong-path instructions are squashed, so the redirect penalty is 2 cycles.
- Load-use (no mem_hold, no redirect):
  - Condition: ex_MemRead & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Response: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1.
  - Lasts exactly 1 cycle, because the load leaves EX.
- x0 never causes a hazard.
- stall_cnt increments in every cycle with pc_en=0. flush_cnt increments in every cycle with ifid_flush=1. Both saturate at all-ones.
- mem_err clears only on reset.
- Reset asserted mid-MEM_WAIT immediately returns the block to RUN and releases all stalls.

Test Plan:
- Reset, then idle inputs -> all enables=1, flushes=0, mem_busy=0, counters 0.
- ex_MemRead=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for 1 cycle -> pc_en=ifid_en=0 and idex_flush=1 for that cycle; stall_cnt=1. Same stimulus with ex_rd=0 -> no stall.
- ex_redirect=1 together with a load-use match -> ifid_flush=idex_flush=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- mem_req=1, mem_ready low 3 cycles then high -> 3 cycles with all enables=0, memwb_bubble=1, mem_busy=1; release in the cycle mem_ready=1; stall_cnt=3.
- mem_req=1 with ex_redirect=1 and mem_ready=0 for 2 cycles -> no flush during the hold; flush asserted in the cycle mem_ready=1; flush_cnt=1.
- MEM_TIMEOUT=4, mem_ready held 0 -> stall in cycles 1-3; in cycle 4 enables=1, memwb_bubble=1, then mem_err=1 (sticky). Assert nrst=0 mid-wait in a second run -> immediate RUN, mem_err=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, EX redirects, multi-cycle data-memory waits.
// Latency: enables/flushes are Mealy (same cycle as the inputs); state, wait counter, error and perf counters are registered.
// Backpressure: a memory access that is not ready freezes every stage until ready or timeout; redirect and load-use are deferred behind it.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemRead,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             mem_busy,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Wait counter only needs to reach MEM_TIMEOUT-1.
    localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WCNT_W-1:0]   r_wait_cnt;
    logic [WCNT_W-1:0]   w_wait_cnt_nxt;
    logic                r_mem_err;
    logic                w_err_set;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic                w_mem_pending;
    logic                w_at_limit;
    logic                w_mem_hold;
    logic                w_timeout;
    logic                w_rs1_hit;
    logic                w_rs2_hit;
    logic                w_load_use;

    // Hazard detection: memory hold, timeout, and load-use match (x0 never matches).
    always_comb begin
        w_mem_pending = mem_req & ~mem_ready;
        w_at_limit    = (r_state == MEM_WAIT) && (r_wait_cnt == WAIT_LAST);
        w_mem_hold    = w_mem_pending & ~w_at_limit;
        w_timeout     = w_mem_pending & w_at_limit;
        w_rs1_hit     = id_uses_rs1 && (id_rs1 == ex_rd);
        w_rs2_hit     = id_uses_rs2 && (id_rs2 == ex_rd);
        w_load_use    = ex_MemRead && (ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);
    end

    // Next-state and wait-counter logic for the memory handshake.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_err_set      = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mem_pending) begin
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (w_mem_hold) begin
                    w_wait_cnt_nxt = r_wait_cnt + WCNT_W'(1);
                end else begin
                    // Ready, timed out, or request withdrawn: back to RUN.
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                    w_err_set      = w_timeout;
                end
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // Stage controls, priority: memory hold, then redirect, then load-use.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = w_timeout;
        mem_busy     = (r_state == MEM_WAIT);
        if (w_mem_hold) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (ex_redirect) begin
            // Squash the two wrong-path instructions in IF/ID and ID/EX.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_load_use) begin
            // Hold PC and IF/ID one cycle, insert a bubble behind the load.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // FSM state, wait counter and sticky timeout error.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_err_set) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    // Saturating stall/flush performance counters.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (ifid_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4 so saturation is reachable).
// Latency: outputs compared mid-cycle against queued expectations; counters compared after each edge.
// Backpressure: none; stimulus is a fixed per-cycle table plus hand sequences.
module tb_pipeline_hazard_ctrl;

    localparam int T_MEM = 4;
    localparam int CW    = 4;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic          clk;
    logic          nrst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_MemRead, ex_redirect, mem_req, mem_ready;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
    logic          memwb_bubble, mem_busy, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T_MEM), .CNT_W(CW)) dut (
        .clk(clk), .nrst(nrst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
        .mem_busy(mem_busy), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, mem_busy, mem_err}
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mrd;
        logic       redir;
        logic       mreq;
        logic       mrdy;
        logic [8:0] exp;
    } vec_t;

    localparam logic [8:0] O_IDLE  = 9'b110101000;
    localparam logic [8:0] O_LU    = 9'b000111000;
    localparam logic [8:0] O_REDIR = 9'b111111000;
    localparam logic [8:0] O_HOLD  = 9'b000000100;
    localparam logic [8:0] O_HOLDW = 9'b000000110;

    vec_t       tbl[$];
    logic [8:0] exp_q[$];
    int         n_checks;
    int         n_fail;
    logic [CW-1:0] exp_stall, exp_flush;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                input logic u2, input logic [4:0] rd, input logic mrd,
                                input logic redir, input logic mreq, input logic mrdy,
                                input logic [8:0] exp);
        vec_t v;
        v = '{rs1, rs2, u1, u2, rd, mrd, redir, mreq, mrdy, exp};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        ex_rd = v.rd; ex_MemRead = v.mrd; ex_redirect = v.redir;
        mem_req = v.mreq; mem_ready = v.mrdy;
    endtask

    function automatic logic [8:0] outs();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, mem_busy, mem_err};
    endfunction

    // One cycle: drive, queue expectation, compare mid-cycle, then compare counters after the edge.
    task automatic apply(input vec_t v, input string name);
        logic [8:0] e;
        drive(v);
        exp_q.push_back(v.exp);
        @(negedge clk);
        e = exp_q.pop_front();
        check({name, "_outs"}, 32'(outs()), 32'(e));
        if (!e[8] && exp_stall != CMAX) exp_stall = exp_stall + 1'b1;
        if (e[6] && exp_flush != CMAX) exp_flush = exp_flush + 1'b1;
        @(posedge clk);
        #1;
        check({name, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
        check({name, "_flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        n_checks = 0;
        n_fail = 0;
        exp_stall = '0;
        exp_flush = '0;
        idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE);

        // Per-cycle table; state carries from one row to the next.
        tbl.push_back(idle);
        tbl.push_back(mk(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU));     // load-use rs2
        tbl.push_back(mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_IDLE));   // rd=x0: no stall
        tbl.push_back(mk(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_LU));     // load-use rs1
        tbl.push_back(mk(5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_IDLE));   // rs1 match but unused
        tbl.push_back(mk(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_REDIR));  // redirect beats load-use
        tbl.push_back(idle);
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_HOLD));   // mem wait 3 cycles
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_HOLDW));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_HOLDW));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b110101010)); // release
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_HOLD));   // redirect deferred
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_HOLDW));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 9'b111111010)); // flush on ready
        tbl.push_back(idle);
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_HOLD));   // timeout run
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_HOLDW));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_HOLDW));
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b110101110)); // timeout cycle
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b110101001)); // err sticky
        tbl.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b110101001)); // ready at once

        // Reset state with idle inputs.
        drive(idle);
        nrst = 1'b0;
        #12;
        check("reset_outs", 32'(outs()), 32'(O_IDLE));
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end
        check("after_table_err", 32'(mem_err), 32'd1);

        // Reset asserted while waiting on memory.
        apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b000000101), "rstwait0");
        apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b000000111), "rstwait1");
        check("rstwait_busy_before", 32'(mem_busy), 32'd1);
        nrst = 1'b0;
        #1;
        check("midrst_busy", 32'(mem_busy), 32'd0);
        check("midrst_err", 32'(mem_err), 32'd0);
        check("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("midrst_flush_cnt", 32'(flush_cnt), 32'd0);
        exp_stall = '0;
        exp_flush = '0;
        drive(idle);
        #1;
        check("midrst_outs", 32'(outs()), 32'(O_IDLE));
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        apply(idle, "post_rst_idle");

        // Counter saturation.
        for (int i = 0; i < 20; i++) begin
            apply(mk(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, O_LU), "sat_lu");
        end
        check("stall_saturated", 32'(stall_cnt), 32'(CMAX));
        for (int i = 0; i < 20; i++) begin
            apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_REDIR), "sat_redir");
        end
        check("flush_saturated", 32'(flush_cnt), 32'(CMAX));
        check("stall_held_at_max", 32'(stall_cnt), 32'(CMAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
